cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter ROB_W, default 4, ROB tag width (matches ROBID).
REQ-002 Parameter DATA_W, default 32, result width.
REQ-003 Parameter DEPTH, fixed 2, per-requester buffer entries.
REQ-004 Port clk  in  1  clock; the only clock, all state on posedge.
REQ-005 Port rst  in  1  reset, synchronous, active-low.
REQ-006 Port rdy  in  1  global enable; low = freeze all state.
REQ-007 Port flush  in  1  mispredict flush; discard all buffered and pending results.
REQ-008 Ports ALU_sgn / LD_sgn / BR_sgn  in  1 each  requester 0/1/2 result valid.
REQ-009 Ports ALU_result / LD_result / BR_result  in  DATA_W each  result value.
REQ-010 Ports ALU_ROB_name / LD_ROB_name / BR_ROB_name  in  ROB_W each  destination ROB tag.
REQ-011 Ports ALU_full / LD_full / BR_full  out  1 each  requester buffer holds DEPTH entries; registered.
REQ-012 Port CDB_sgn  out  1  broadcast valid; registered.
REQ-013 Port CDB_result  out  DATA_W  broadcast value; registered.
REQ-014 Port CDB_ROB_name  out  ROB_W  broadcast tag; registered.
REQ-015 Port CDB_src  out  2  source index of broadcast (0 ALU, 1 LD, 2 BR); registered.
REQ-016 Port pending  out  1  any buffer non-empty; combinational from counts.

Function
REQ-017 Each requester owns an in-order FIFO of DEPTH entries {result, tag}, with a 2-bit count (0..2) and 1-bit head/tail pointers that wrap modulo 2.
REQ-018 Push: on a posedge with rst high, rdy high, flush low, X_sgn high and X_full low, the entry is written at tail; the tail advances and the count increments.
REQ-019 X_sgn while X_full is high is a protocol violation; the entry is dropped and the state is unchanged (the bench asserts this never happens).
REQ-020 X_full reflects the count at the previous edge; a push is refused when full even if that buffer pops on the same edge.
REQ-021 Arbitration: each cycle, among non-empty buffers, grant the first in round-robin order starting at (last_grant+1) mod 3.
REQ-022 Grant takes effect at the posedge: the head entry is popped, CDB_* register {1, result, tag, src}, and last_grant <= src.
REQ-023 At most one broadcast per cycle; if no buffer is non-empty, CDB_sgn <= 0 and CDB_result/CDB_ROB_name/CDB_src hold their previous values.
REQ-024 There is no bypass: an entry pushed at edge E is broadcast at edge E+1 at earliest, so latency is 1 to 2+ cycles under contention.
REQ-025 Simultaneous push and pop on the same FIFO leaves the count unchanged, and both pointers advance.
REQ-026 Fairness: with all three buffers continuously non-empty, grants rotate 0,1,2,0,...; no requester waits more than 2 broadcasts once at head.
REQ-027 Flush (rdy high): all counts <= 0, pointers <= 0, CDB_sgn <= 0; any pushes on the same edge are discarded; last_grant is retained.
REQ-028 rdy low: no push, pop, flush or grant; all registers hold, and CDB_sgn holds its value (consumers qualify with rdy).
REQ-029 Priority at a posedge: rst, then rdy, then flush, then normal push/pop.

Reset
REQ-030 On a posedge with rst low: all counts 0, pointers 0, last_grant = 2, CDB_sgn 0, CDB_result 0, CDB_ROB_name 0, CDB_src 0, all X_full 0, pending 0.
REQ-031 Reset mid-operation discards all buffered entries; no broadcast occurs on the edge following reset release without a new push.

Verification
REQ-032 Single push: ALU_sgn=1, ALU_result=32'h0000_00AA, tag 3 at edge E -> at edge E+1, CDB_sgn=1, result 32'hAA, tag 3, src 0; at E+2, CDB_sgn=0.
REQ-033 Contention: all three push at edge E after reset (tags 1,2,3) -> broadcasts at E+1, E+2, E+3 with src 0, 1, 2, then CDB_sgn=0.
REQ-034 Full/backpressure: LD pushes tags 4, 5 on consecutive edges while ALU and BR hold the grant -> LD_full=1; the third LD push is withheld and order 4 then 5 is preserved on the CDB.
REQ-035 Flush: buffers hold 3 entries and flush=1 with a concurrent BR push -> the next edge gives CDB_sgn=0, pending=0, and the BR entry is never broadcast.
REQ-036 Stall/reset: rdy=0 for 3 cycles with entries buffered -> the CDB outputs are frozen and the stream resumes in order; rst=0 mid-stream -> all outputs reach their REQ-030 values.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus arbiter for three result producers (ALU, LD, BR).
// Each producer writes into its own two-entry in-order FIFO. One head entry per
// cycle is broadcast on the CDB, chosen round-robin starting after the last grant.
//
// Ports:
//   clk, rst (sync, active-low), rdy (global enable), flush (discard all results)
//   {ALU,LD,BR}_sgn/_result/_ROB_name : producer result valid, value, ROB tag
//   {ALU,LD,BR}_full                  : producer FIFO holds DEPTH entries (registered)
//   CDB_sgn/_result/_ROB_name/_src    : registered broadcast (src 0 ALU, 1 LD, 2 BR)
//   pending                           : any FIFO non-empty (combinational from counts)
module cdb_arbiter #(
    parameter int unsigned ROB_W  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              ALU_sgn,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [ROB_W-1:0]  ALU_ROB_name,
    input  logic              LD_sgn,
    input  logic [DATA_W-1:0] LD_result,
    input  logic [ROB_W-1:0]  LD_ROB_name,
    input  logic              BR_sgn,
    input  logic [DATA_W-1:0] BR_result,
    input  logic [ROB_W-1:0]  BR_ROB_name,
    output logic              ALU_full,
    output logic              LD_full,
    output logic              BR_full,
    output logic              CDB_sgn,
    output logic [DATA_W-1:0] CDB_result,
    output logic [ROB_W-1:0]  CDB_ROB_name,
    output logic [1:0]        CDB_src,
    output logic              pending
);

    localparam int unsigned N_REQ = 3;
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [ROB_W-1:0]  tag;
    } entry_t;

    entry_t           in_entry   [N_REQ];
    entry_t           head_entry [N_REQ];
    logic [N_REQ-1:0] in_sgn;
    logic [N_REQ-1:0] nonempty;
    logic [N_REQ-1:0] full;

    logic             advance;
    logic             grant_vld;
    logic [1:0]       grant_idx;
    entry_t           grant_entry;

    logic             cdb_sgn_q;
    logic [DATA_W-1:0] cdb_result_q;
    logic [ROB_W-1:0] cdb_tag_q;
    logic [1:0]       cdb_src_q;
    logic [1:0]       last_grant_q;

    assign in_sgn      = {BR_sgn, LD_sgn, ALU_sgn};
    assign in_entry[0] = {ALU_result, ALU_ROB_name};
    assign in_entry[1] = {LD_result, LD_ROB_name};
    assign in_entry[2] = {BR_result, BR_ROB_name};

    // Normal push/pop only when enabled and not flushing.
    assign advance = rdy && !flush;

    // Round-robin grant: search starts one past the last granted requester.
    always_comb begin
        grant_vld = |nonempty;
        grant_idx = 2'd0;
        case (last_grant_q)
            2'd0: begin
                if (nonempty[1])      grant_idx = 2'd1;
                else if (nonempty[2]) grant_idx = 2'd2;
                else                  grant_idx = 2'd0;
            end
            2'd1: begin
                if (nonempty[2])      grant_idx = 2'd2;
                else if (nonempty[0]) grant_idx = 2'd0;
                else                  grant_idx = 2'd1;
            end
            default: begin
                if (nonempty[0])      grant_idx = 2'd0;
                else if (nonempty[1]) grant_idx = 2'd1;
                else                  grant_idx = 2'd2;
            end
        endcase
    end

    // Head entry of the granted FIFO.
    always_comb begin
        grant_entry = head_entry[0];
        case (grant_idx)
            2'd1:    grant_entry = head_entry[1];
            2'd2:    grant_entry = head_entry[2];
            default: grant_entry = head_entry[0];
        endcase
    end

    // Per-requester two-entry FIFO.
    for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
        entry_t           mem [DEPTH];
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] count_d;
        logic             head_q;
        logic             head_d;
        logic             tail_q;
        logic             tail_d;
        logic             full_q;
        logic             full_d;
        logic             push;
        logic             pop;

        // Next pointers/count; a full FIFO refuses a push even if it pops this edge.
        always_comb begin
            push    = advance && in_sgn[g] && !full_q;
            pop     = advance && grant_vld && (grant_idx == 2'(g));
            count_d = count_q;
            head_d  = head_q;
            tail_d  = tail_q;
            if (rdy && flush) begin
                count_d = '0;
                head_d  = 1'b0;
                tail_d  = 1'b0;
            end else begin
                if (push) tail_d = ~tail_q;
                if (pop)  head_d = ~head_q;
                if (push && !pop)      count_d = count_q + CNT_W'(1);
                else if (pop && !push) count_d = count_q - CNT_W'(1);
            end
            full_d = (count_d == CNT_FULL);
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                count_q <= '0;
                head_q  <= 1'b0;
                tail_q  <= 1'b0;
                full_q  <= 1'b0;
            end else begin
                count_q <= count_d;
                head_q  <= head_d;
                tail_q  <= tail_d;
                full_q  <= full_d;
            end
        end

        // Payload storage needs no reset; occupancy is tracked by count_q.
        always_ff @(posedge clk) begin
            if (rst && push) mem[tail_q] <= in_entry[g];
        end

        assign head_entry[g] = mem[head_q];
        assign nonempty[g]   = (count_q != '0);
        assign full[g]       = full_q;
    end

    // Broadcast registers; tag/result/src hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cdb_sgn_q    <= 1'b0;
            cdb_result_q <= '0;
            cdb_tag_q    <= '0;
            cdb_src_q    <= 2'd0;
            last_grant_q <= 2'd2;
        end else if (rdy) begin
            if (flush) begin
                cdb_sgn_q <= 1'b0;
            end else if (grant_vld) begin
                cdb_sgn_q    <= 1'b1;
                cdb_result_q <= grant_entry.result;
                cdb_tag_q    <= grant_entry.tag;
                cdb_src_q    <= grant_idx;
                last_grant_q <= grant_idx;
            end else begin
                cdb_sgn_q <= 1'b0;
            end
        end
    end

    assign ALU_full     = full[0];
    assign LD_full      = full[1];
    assign BR_full      = full[2];
    assign CDB_sgn      = cdb_sgn_q;
    assign CDB_result   = cdb_result_q;
    assign CDB_ROB_name = cdb_tag_q;
    assign CDB_src      = cdb_src_q;
    assign pending      = |nonempty;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter with a queue-based reference
// model; every broadcast the model predicts is pushed to a scoreboard and
// popped when the DUT presents it.
module tb_cdb_arbiter;

    localparam int unsigned ROB_W  = 4;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              flush;
    logic              ALU_sgn;
    logic [DATA_W-1:0] ALU_result;
    logic [ROB_W-1:0]  ALU_ROB_name;
    logic              LD_sgn;
    logic [DATA_W-1:0] LD_result;
    logic [ROB_W-1:0]  LD_ROB_name;
    logic              BR_sgn;
    logic [DATA_W-1:0] BR_result;
    logic [ROB_W-1:0]  BR_ROB_name;
    logic              ALU_full;
    logic              LD_full;
    logic              BR_full;
    logic              CDB_sgn;
    logic [DATA_W-1:0] CDB_result;
    logic [ROB_W-1:0]  CDB_ROB_name;
    logic [1:0]        CDB_src;
    logic              pending;

    cdb_arbiter #(.ROB_W(ROB_W), .DATA_W(DATA_W), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .ALU_sgn(ALU_sgn), .ALU_result(ALU_result), .ALU_ROB_name(ALU_ROB_name),
        .LD_sgn(LD_sgn), .LD_result(LD_result), .LD_ROB_name(LD_ROB_name),
        .BR_sgn(BR_sgn), .BR_result(BR_result), .BR_ROB_name(BR_ROB_name),
        .ALU_full(ALU_full), .LD_full(LD_full), .BR_full(BR_full),
        .CDB_sgn(CDB_sgn), .CDB_result(CDB_result), .CDB_ROB_name(CDB_ROB_name),
        .CDB_src(CDB_src), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
    } ent_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
        logic [1:0]  s;
    } bc_t;

    ent_t        mq [3][$];
    bc_t         sb [$];
    logic [3:0]  ld_seen [$];
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  m_last = 2'd2;
    logic        m_sgn = 1'b0;
    logic [31:0] m_res = '0;
    logic [3:0]  m_tag = '0;
    logic [1:0]  m_src = '0;
    bit          new_bc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int total_q();
        return mq[0].size() + mq[1].size() + mq[2].size();
    endfunction

    // Reference model, evaluated with the inputs that were stable at the edge.
    task automatic model_edge();
        logic [2:0]  s;
        logic [31:0] d [3];
        logic [3:0]  t [3];
        bit          fullpre [3];
        int          g;
        s    = {BR_sgn, LD_sgn, ALU_sgn};
        d[0] = ALU_result; d[1] = LD_result; d[2] = BR_result;
        t[0] = ALU_ROB_name; t[1] = LD_ROB_name; t[2] = BR_ROB_name;
        new_bc = 1'b0;
        if (!rst) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            m_last = 2'd2; m_sgn = 1'b0; m_res = '0; m_tag = '0; m_src = '0;
        end else if (rdy) begin
            if (flush) begin
                for (int i = 0; i < 3; i++) mq[i].delete();
                m_sgn = 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) fullpre[i] = (mq[i].size() >= 2);
                g = -1;
                for (int k = 0; k < 3; k++) begin
                    int idx;
                    idx = (int'(m_last) + 1 + k) % 3;
                    if (g < 0 && mq[idx].size() > 0) g = idx;
                end
                if (g >= 0) begin
                    ent_t e;
                    e      = mq[g].pop_front();
                    m_sgn  = 1'b1;
                    m_res  = e.d;
                    m_tag  = e.t;
                    m_src  = 2'(g);
                    m_last = 2'(g);
                    new_bc = 1'b1;
                    sb.push_back('{e.d, e.t, 2'(g)});
                end else begin
                    m_sgn = 1'b0;
                end
                for (int i = 0; i < 3; i++)
                    if (s[i] && !fullpre[i]) mq[i].push_back('{d[i], t[i]});
            end
        end
    endtask

    task automatic sample();
        bc_t b;
        chk("cdb_sgn", 32'(CDB_sgn), 32'(m_sgn));
        if (new_bc) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                b = sb.pop_front();
                chk("bc_result", CDB_result, b.d);
                chk("bc_tag", 32'(CDB_ROB_name), 32'(b.t));
                chk("bc_src", 32'(CDB_src), 32'(b.s));
                if (CDB_src == 2'd1) ld_seen.push_back(CDB_ROB_name);
            end
        end else begin
            chk("hold_result", CDB_result, m_res);
            chk("hold_tag", 32'(CDB_ROB_name), 32'(m_tag));
            chk("hold_src", 32'(CDB_src), 32'(m_src));
        end
        chk("alu_full", 32'(ALU_full), 32'(mq[0].size() == 2));
        chk("ld_full", 32'(LD_full), 32'(mq[1].size() == 2));
        chk("br_full", 32'(BR_full), 32'(mq[2].size() == 2));
        chk("pending", 32'(pending), 32'(total_q() != 0));
    endtask

    task automatic tick();
        chk("protocol", 32'({ALU_sgn & ALU_full, LD_sgn & LD_full, BR_sgn & BR_full}), 32'd0);
        @(posedge clk);
        model_edge();
        #1;
        sample();
    endtask

    task automatic idle();
        ALU_sgn = 1'b0; LD_sgn = 1'b0; BR_sgn = 1'b0;
    endtask

    task automatic push_all(input logic [3:0] ta, input logic [3:0] tl, input logic [3:0] tb);
        ALU_sgn = 1'b1; ALU_result = 32'h1000 + 32'(ta); ALU_ROB_name = ta;
        LD_sgn  = 1'b1; LD_result  = 32'h2000 + 32'(tl); LD_ROB_name  = tl;
        BR_sgn  = 1'b1; BR_result  = 32'h3000 + 32'(tb); BR_ROB_name  = tb;
    endtask

    task automatic drain();
        idle();
        for (int n = 0; n < 20 && total_q() != 0; n++) tick();
        chk("drain_empty", 32'(total_q()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        ALU_result = '0; ALU_ROB_name = '0; LD_result = '0; LD_ROB_name = '0;
        BR_result = '0; BR_ROB_name = '0;
        idle();

        // Reset values
        tick(); tick();
        chk("rst_sgn", 32'(CDB_sgn), 32'd0);
        chk("rst_result", CDB_result, 32'd0);
        chk("rst_tag", 32'(CDB_ROB_name), 32'd0);
        chk("rst_src", 32'(CDB_src), 32'd0);
        chk("rst_full", 32'({ALU_full, LD_full, BR_full}), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        rst = 1'b1;
        tick();
        chk("rel_sgn", 32'(CDB_sgn), 32'd0);

        // Single push
        ALU_sgn = 1'b1; ALU_result = 32'h0000_00AA; ALU_ROB_name = 4'd3;
        tick();
        idle();
        chk("single_no_bypass", 32'(CDB_sgn), 32'd0);
        tick();
        chk("single_sgn", 32'(CDB_sgn), 32'd1);
        chk("single_result", CDB_result, 32'h0000_00AA);
        chk("single_tag", 32'(CDB_ROB_name), 32'd3);
        chk("single_src", 32'(CDB_src), 32'd0);
        tick();
        chk("single_done", 32'(CDB_sgn), 32'd0);

        // Contention right after reset: order 0,1,2
        do_reset();
        push_all(4'd1, 4'd2, 4'd3);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("cont_sgn", 32'(CDB_sgn), 32'd1);
            chk("cont_src", 32'(CDB_src), 32'(k));
            chk("cont_tag", 32'(CDB_ROB_name), 32'(k + 1));
        end
        tick();
        chk("cont_done", 32'(CDB_sgn), 32'd0);

        // Backpressure on LD while ALU and BR compete
        do_reset();
        ld_seen.delete();
        push_all(4'd7, 4'd4, 4'd8);
        tick();
        push_all(4'd9, 4'd5, 4'd10);
        tick();
        chk("ld_full_set", 32'(LD_full), 32'd1);
        begin
            logic [3:0] ld_tag;
            logic [3:0] xt;
            ld_tag = 4'd6;
            xt     = 4'd11;
            for (int n = 0; n < 8; n++) begin
                ALU_sgn = !ALU_full; ALU_result = 32'h1000 + 32'(xt); ALU_ROB_name = xt;
                BR_sgn  = !BR_full;  BR_result  = 32'h3000 + 32'(xt); BR_ROB_name  = xt;
                LD_sgn  = (ld_tag == 4'd6) && !LD_full;
                LD_result = 32'h2000 + 32'(ld_tag); LD_ROB_name = ld_tag;
                tick();
                if (LD_sgn) ld_tag = 4'd0;
                xt = xt + 4'd1;
            end
        end
        drain();
        chk("ld_order_len", 32'(ld_seen.size()), 32'd3);
        if (ld_seen.size() == 3) begin
            chk("ld_order_0", 32'(ld_seen[0]), 32'd4);
            chk("ld_order_1", 32'(ld_seen[1]), 32'd5);
            chk("ld_order_2", 32'(ld_seen[2]), 32'd6);
        end

        // Flush with a concurrent BR push
        push_all(4'd1, 4'd2, 4'd3);
        tick();
        idle();
        flush = 1'b1;
        BR_sgn = 1'b1; BR_result = 32'hDEAD_BEEF; BR_ROB_name = 4'd12;
        tick();
        flush = 1'b0;
        idle();
        chk("flush_sgn", 32'(CDB_sgn), 32'd0);
        chk("flush_pending", 32'(pending), 32'd0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("flush_quiet", 32'(CDB_sgn), 32'd0);
        end

        // Stall with entries buffered
        push_all(4'd13, 4'd14, 4'd15);
        tick();
        idle();
        tick();
        rdy = 1'b0;
        ALU_sgn = 1'b1; ALU_result = 32'h5555_5555; ALU_ROB_name = 4'd9;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("stall_sgn", 32'(CDB_sgn), 32'd1);
            chk("stall_pending", 32'(pending), 32'd1);
        end
        idle();
        rdy = 1'b1;
        drain();

        // Reset mid-stream
        push_all(4'd1, 4'd2, 4'd3);
        tick();
        idle();
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_sgn", 32'(CDB_sgn), 32'd0);
        chk("mrst_result", CDB_result, 32'd0);
        chk("mrst_tag", 32'(CDB_ROB_name), 32'd0);
        chk("mrst_src", 32'(CDB_src), 32'd0);
        chk("mrst_full", 32'({ALU_full, LD_full, BR_full}), 32'd0);
        chk("mrst_pending", 32'(pending), 32'd0);
        rst = 1'b1;
        tick();
        chk("mrst_rel_sgn", 32'(CDB_sgn), 32'd0);
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
